// File: rtl/swervolf_ram_init.sv
// AXI4 write-burst engine that fills a RAM with FILL_PATTERN after start.
// Define RAM_INIT_AUTOSTART_EN to begin the fill automatically after reset.
module swervolf_ram_init #(
  parameter logic [31:0] RAM_SIZE     = 32'h100000,
  parameter int          BURST_LEN    = 16,
  parameter int          ID_WIDTH     = 6,
  parameter logic [63:0] FILL_PATTERN = 64'h0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_init_done,
  output logic                o_init_error,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] awaddr_nxt;
  logic [7:0]  beat_cnt;
  logic [7:0]  beat_nxt;
  logic        done_nxt;
  logic        error_nxt;
  logic        idle_start;
  logic        last_burst;
  logic        unused_bid;

  assign unused_bid = ^i_bid;

  assign o_awid    = '0;
  assign o_awlen   = LAST_BEAT;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_wdata   = FILL_PATTERN;
  assign o_wstrb   = 8'hFF;

`ifdef RAM_INIT_AUTOSTART_EN
  // One-shot request that is live only for the first edge after reset.
  logic auto_pend;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      auto_pend <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
    end
  end

  assign idle_start = i_start | auto_pend;
`else
  assign idle_start = i_start;
`endif

  assign last_burst = (o_awaddr + BURST_BYTES) == RAM_SIZE;

  always_comb begin
    state_nxt  = state;
    awaddr_nxt = o_awaddr;
    beat_nxt   = beat_cnt;
    done_nxt   = o_init_done;
    error_nxt  = o_init_error;
    unique case (state)
      S_IDLE: begin
        if (idle_start) begin
          state_nxt  = S_ADDR;
          awaddr_nxt = '0;
          beat_nxt   = '0;
          done_nxt   = 1'b0;
          error_nxt  = 1'b0;
        end
      end
      S_ADDR: begin
        if (i_awready) begin
          state_nxt = S_DATA;
          beat_nxt  = '0;
        end
      end
      S_DATA: begin
        if (i_wready) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = S_RESP;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + 8'd1;
          end
        end
      end
      S_RESP: begin
        if (i_bvalid) begin
          if (i_bresp != 2'b00) begin
            error_nxt = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else if (last_burst) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            awaddr_nxt = o_awaddr + BURST_BYTES;
            state_nxt  = S_ADDR;
          end
        end
      end
      S_DONE: begin
        if (i_start) begin
          state_nxt  = S_ADDR;
          awaddr_nxt = '0;
          beat_nxt   = '0;
          done_nxt   = 1'b0;
          error_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so every AXI output is a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      beat_cnt     <= '0;
      o_awaddr     <= '0;
      o_busy       <= 1'b0;
      o_init_done  <= 1'b0;
      o_init_error <= 1'b0;
      o_awvalid    <= 1'b0;
      o_wvalid     <= 1'b0;
      o_wlast      <= 1'b0;
      o_bready     <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_nxt;
      o_awaddr     <= awaddr_nxt;
      o_init_done  <= done_nxt;
      o_init_error <= error_nxt;
      o_busy       <= (state_nxt == S_ADDR) || (state_nxt == S_DATA) || (state_nxt == S_RESP);
      o_awvalid    <= (state_nxt == S_ADDR);
      o_wvalid     <= (state_nxt == S_DATA);
      o_wlast      <= (state_nxt == S_DATA) && (beat_nxt == LAST_BEAT);
      o_bready     <= (state_nxt == S_RESP);
    end
  end

endmodule

// File: tb/tb_swervolf_ram_init.sv
// Directed bench for swervolf_ram_init: 256-byte RAM, 4-beat bursts,
// with an AXI write slave model that scoreboards every handshake.
module tb_swervolf_ram_init;

  localparam logic [31:0] RAM_SIZE  = 32'd256;
  localparam int          BURST_LEN = 4;
  localparam int          ID_WIDTH  = 4;
  localparam logic [63:0] PATTERN   = 64'hDEAD_BEEF_0123_4567;

  logic                clk;
  logic                rstn;
  logic                i_start;
  logic                o_busy;
  logic                o_init_done;
  logic                o_init_error;
  logic [ID_WIDTH-1:0] o_awid;
  logic [31:0]         o_awaddr;
  logic [7:0]          o_awlen;
  logic [2:0]          o_awsize;
  logic [1:0]          o_awburst;
  logic                o_awvalid;
  logic                i_awready;
  logic [63:0]         o_wdata;
  logic [7:0]          o_wstrb;
  logic                o_wlast;
  logic                o_wvalid;
  logic                i_wready;
  logic [ID_WIDTH-1:0] i_bid;
  logic [1:0]          i_bresp;
  logic                i_bvalid;
  logic                o_bready;

  int total;
  int bad;

  int aw_count;
  int w_count;
  int b_count;
  int beat;
  int pending_b;
  bit aw_open;
  bit stall_en;
  int err_burst;
  int aw_wait;
  int w_wait;
  int b_wait;
  bit aw_held;
  bit w_held;
  logic [31:0] held_addr;
  logic [63:0] held_data;
  logic        held_last;

  swervolf_ram_init #(
    .RAM_SIZE     (RAM_SIZE),
    .BURST_LEN    (BURST_LEN),
    .ID_WIDTH     (ID_WIDTH),
    .FILL_PATTERN (PATTERN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_init_done  (o_init_done),
    .o_init_error (o_init_error),
    .o_awid       (o_awid),
    .o_awaddr     (o_awaddr),
    .o_awlen      (o_awlen),
    .o_awsize     (o_awsize),
    .o_awburst    (o_awburst),
    .o_awvalid    (o_awvalid),
    .i_awready    (i_awready),
    .o_wdata      (o_wdata),
    .o_wstrb      (o_wstrb),
    .o_wlast      (o_wlast),
    .o_wvalid     (o_wvalid),
    .i_wready     (i_wready),
    .i_bid        (i_bid),
    .i_bresp      (i_bresp),
    .i_bvalid     (i_bvalid),
    .o_bready     (o_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at negedge+1; holds start for exactly one rising edge.
  task automatic applyStimulus();
    i_start = 1'b1;
    @(negedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic clearScoreboard();
    aw_count  = 0;
    w_count   = 0;
    b_count   = 0;
    beat      = 0;
    pending_b = 0;
    aw_open   = 1'b0;
    aw_wait   = 2;
    w_wait    = 1;
    b_wait    = 3;
  endtask

  task automatic waitDone(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (o_init_done) break;
      @(negedge clk);
      #1;
    end
    checkOutput("done_wait", o_init_done, 1);
  endtask

  task automatic checkFullFill(input string tag);
    checkOutput({tag, "_aw_count"}, aw_count, 8);
    checkOutput({tag, "_w_count"}, w_count, 32);
    checkOutput({tag, "_b_count"}, b_count, 8);
    checkOutput({tag, "_done"}, o_init_done, 1);
    checkOutput({tag, "_error"}, o_init_error, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
  endtask

  // AXI write slave: drives ready/response at negedge and scoreboards the
  // handshakes that the following rising edge will complete.
  initial begin
    bit aw_hs;
    bit w_hs;
    bit b_hs;
    i_awready = 1'b0;
    i_wready  = 1'b0;
    i_bvalid  = 1'b0;
    i_bresp   = 2'b00;
    i_bid     = '0;
    aw_held   = 1'b0;
    w_held    = 1'b0;
    held_addr = '0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        clearScoreboard();
        i_awready = 1'b0;
        i_wready  = 1'b0;
        i_bvalid  = 1'b0;
        i_bresp   = 2'b00;
        aw_held   = 1'b0;
        w_held    = 1'b0;
        continue;
      end
      if (aw_held) begin
        checkOutput("aw_hold_valid", o_awvalid, 1);
        checkOutput("aw_hold_addr", o_awaddr, held_addr);
      end
      if (w_held) begin
        checkOutput("w_hold_valid", o_wvalid, 1);
        checkOutput("w_hold_data", o_wdata, held_data);
        checkOutput("w_hold_last", o_wlast, held_last);
      end
      if (o_wvalid) checkOutput("w_after_aw", aw_open, 1);

      if (stall_en) begin
        i_awready = (aw_wait == 0);
        if (o_awvalid && aw_wait > 0) aw_wait--;
        i_wready = (w_wait == 0);
        if (o_wvalid && w_wait > 0) w_wait--;
      end else begin
        i_awready = 1'b1;
        i_wready  = 1'b1;
      end
      if (pending_b > 0) begin
        if (stall_en && b_wait > 0) begin
          i_bvalid = 1'b0;
          b_wait--;
        end else begin
          i_bvalid = 1'b1;
          i_bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
        end
      end else begin
        i_bvalid = stall_en && ($urandom_range(0, 3) == 0);
        i_bresp  = 2'b11;
      end

      aw_hs = o_awvalid && i_awready;
      w_hs  = o_wvalid && i_wready;
      b_hs  = o_bready && i_bvalid;
      if (aw_hs) begin
        checkOutput("awaddr", o_awaddr, 64'(aw_count * 32));
        checkOutput("aw_single_outstanding", aw_open, 0);
        aw_count++;
        aw_open = 1'b1;
        aw_wait = $urandom_range(0, 5);
      end
      if (w_hs) begin
        checkOutput("wdata", o_wdata, PATTERN);
        checkOutput("wlast", o_wlast, (beat == BURST_LEN - 1) ? 1 : 0);
        w_count++;
        beat++;
        w_wait = $urandom_range(0, 5);
        if (beat == BURST_LEN) begin
          beat      = 0;
          aw_open   = 1'b0;
          pending_b++;
        end
      end
      if (b_hs) begin
        checkOutput("b_expected", (pending_b > 0) ? 1 : 0, 1);
        if (pending_b > 0) pending_b--;
        b_count++;
        b_wait = $urandom_range(0, 5);
      end
      aw_held   = o_awvalid && !i_awready;
      w_held    = o_wvalid && !i_wready;
      held_addr = o_awaddr;
      held_data = o_wdata;
      held_last = o_wlast;
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    stall_en  = 1'b0;
    err_burst = -1;
    clearScoreboard();
    rstn      = 1'b0;
    i_start   = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_init_done, 0);
    checkOutput("rst_error", o_init_error, 0);
    checkOutput("rst_awvalid", o_awvalid, 0);
    checkOutput("rst_wvalid", o_wvalid, 0);
    checkOutput("rst_wlast", o_wlast, 0);
    checkOutput("rst_bready", o_bready, 0);
    checkOutput("rst_awaddr", o_awaddr, 0);
    checkOutput("const_awid", o_awid, 0);
    checkOutput("const_awlen", o_awlen, 3);
    checkOutput("const_awsize", o_awsize, 3);
    checkOutput("const_awburst", o_awburst, 1);
    checkOutput("const_wstrb", o_wstrb, 8'hFF);
    checkOutput("const_wdata", o_wdata, PATTERN);

    rstn = 1'b1;
    @(negedge clk);
    #1;
`ifdef RAM_INIT_AUTOSTART_EN
    checkOutput("autostart_awvalid", o_awvalid, 1);
    waitDone(3000);
`else
    repeat (4) @(negedge clk);
    #1;
    checkOutput("idle_no_start_busy", o_busy, 0);
    checkOutput("idle_no_start_awvalid", o_awvalid, 0);
`endif

    // Clean fill; a second start pulse lands while the first response is pending.
    clearScoreboard();
    applyStimulus();
    checkOutput("start_busy", o_busy, 1);
    checkOutput("start_awvalid", o_awvalid, 1);
    checkOutput("start_awaddr", o_awaddr, 0);
    checkOutput("start_done_low", o_init_done, 0);
    for (int i = 0; i < 50; i++) begin
      if (o_bready) break;
      @(negedge clk);
      #1;
    end
    checkOutput("bready_wait", o_bready, 1);
    applyStimulus();
    checkOutput("start_in_resp_busy", o_busy, 1);
    waitDone(2000);
    checkFullFill("clean");

    // Restart from DONE with random ready/response stalls.
    stall_en = 1'b1;
    clearScoreboard();
    applyStimulus();
    checkOutput("restart_done_low", o_init_done, 0);
    checkOutput("restart_busy", o_busy, 1);
    waitDone(3000);
    checkFullFill("stall");
    stall_en = 1'b0;

    // Error response on the third burst stops the fill.
    err_burst = 2;
    clearScoreboard();
    applyStimulus();
    waitDone(2000);
    checkOutput("err_aw_count", aw_count, 3);
    checkOutput("err_w_count", w_count, 12);
    checkOutput("err_flag", o_init_error, 1);
    checkOutput("err_done", o_init_done, 1);
    checkOutput("err_busy", o_busy, 0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("err_no_more_aw", aw_count, 3);
    checkOutput("err_awvalid_idle", o_awvalid, 0);
    err_burst = -1;

    // Reset during the data phase of the second burst, then refill.
    clearScoreboard();
    applyStimulus();
    for (int i = 0; i < 200; i++) begin
      if (aw_count == 2 && o_wvalid) break;
      @(negedge clk);
      #1;
    end
    checkOutput("midrst_in_data2", (aw_count == 2 && o_wvalid) ? 1 : 0, 1);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_awvalid", o_awvalid, 0);
    checkOutput("midrst_wvalid", o_wvalid, 0);
    checkOutput("midrst_wlast", o_wlast, 0);
    checkOutput("midrst_bready", o_bready, 0);
    checkOutput("midrst_awaddr", o_awaddr, 0);
    checkOutput("midrst_done", o_init_done, 0);
    checkOutput("midrst_error", o_init_error, 0);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
`ifndef RAM_INIT_AUTOSTART_EN
    applyStimulus();
    checkOutput("midrst_restart_awaddr", o_awaddr, 0);
`endif
    waitDone(2000);
    checkFullFill("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
